// File: rtl/stream_pkg.sv
// Shared types for the valid/ready stream pipeline: slice modes, skid slice
// states and the width of the occupancy counter.
package stream_pkg;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        FWD  = 2'd1,
        SKID = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } slice_state_t;

    // The counter has to reach 2*stages, the capacity of a chain of skid slices.
    function automatic int count_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/stream_if.sv
// Valid/ready stream bundle shared by every producer/consumer pair in the
// design; the master drives valid/data and the slave answers with ready.
interface stream_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/handshake_slice.sv
// One register slice of the stream pipeline: a forward slice (registered
// valid/data) or a two-entry skid slice (valid/data and ready all registered).
module handshake_slice
    import stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MODE  = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    stream_if.slave  up,
    stream_if.master dn
);

    localparam mode_t SLICE_MODE = mode_t'(MODE);

    logic up_fire;

    assign up_fire = up.valid && up.ready;

    generate
        if (SLICE_MODE == SKID) begin : g_skid
            slice_state_t     state_q;
            slice_state_t     state_d;
            logic [WIDTH-1:0] main_q;
            logic [WIDTH-1:0] skid_q;
            logic             ready_q;
            logic             dn_fire;
            logic             load_main_up;
            logic             load_main_skid;
            logic             load_skid;

            assign dn_fire  = dn.valid && dn.ready;
            assign dn.valid = (state_q != EMPTY);
            assign dn.data  = main_q;
            assign up.ready = ready_q;

            always_comb begin
                state_d        = state_q;
                load_main_up   = 1'b0;
                load_main_skid = 1'b0;
                load_skid      = 1'b0;
                case (state_q)
                    EMPTY: begin
                        if (up_fire) begin
                            state_d      = BUSY;
                            load_main_up = 1'b1;
                        end
                    end
                    BUSY: begin
                        if (up_fire && dn_fire) begin
                            load_main_up = 1'b1;
                        end else if (up_fire) begin
                            load_skid = 1'b1;
                            state_d   = FULL;
                        end else if (dn_fire) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        if (dn_fire) begin
                            load_main_skid = 1'b1;
                            state_d        = BUSY;
                        end
                    end
                    default: begin
                        state_d = EMPTY;
                    end
                endcase
            end

            // ready is computed from the next state so it comes straight out of
            // a flop and never depends on this cycle's downstream ready.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    state_q <= EMPTY;
                    ready_q <= 1'b1;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state_q <= state_d;
                    ready_q <= (state_d != FULL);
                    if (load_main_up) begin
                        main_q <= up.data;
                    end else if (load_main_skid) begin
                        main_q <= skid_q;
                    end
                    if (load_skid) begin
                        skid_q <= up.data;
                    end
                end
            end
        end else begin : g_fwd
            logic             valid_q;
            logic [WIDTH-1:0] data_q;

            assign dn.valid = valid_q;
            assign dn.data  = data_q;
            assign up.ready = !valid_q || dn.ready;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else if (up_fire) begin
                    valid_q <= 1'b1;
                    data_q  <= up.data;
                end else if (dn.ready) begin
                    valid_q <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/handshake_pipe.sv
// Parametrised valid/ready pipeline: STAGES chained slices between an upstream
// and a downstream stream port, with synchronous flush and an occupancy count.
module handshake_pipe
    import stream_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int MODE   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    stream_if.slave                         up,
    stream_if.master                        dn,
    output logic [count_width(STAGES)-1:0]  count
);

    localparam int    CW        = count_width(STAGES);
    localparam mode_t PIPE_MODE = mode_t'(MODE);

    generate
        if (PIPE_MODE == PASS) begin : g_pass
            assign dn.valid = up.valid;
            assign dn.data  = up.data;
            assign up.ready = dn.ready;
            assign count    = '0;
        end else begin : g_pipe
            stream_if #(.WIDTH(WIDTH)) link [0:STAGES] ();

            logic [CW-1:0] count_q;
            logic          up_fire;
            logic          dn_fire;

            assign link[0].valid      = up.valid;
            assign link[0].data       = up.data;
            assign up.ready           = link[0].ready;
            assign dn.valid           = link[STAGES].valid;
            assign dn.data            = link[STAGES].data;
            assign link[STAGES].ready = dn.ready;

            for (genvar i = 0; i < STAGES; i++) begin : g_slice
                handshake_slice #(
                    .WIDTH (WIDTH),
                    .MODE  (MODE)
                ) u_slice (
                    .clk   (clk),
                    .rst   (rst),
                    .flush (flush),
                    .up    (link[i]),
                    .dn    (link[i+1])
                );
            end

            assign up_fire = up.valid && up.ready;
            assign dn_fire = dn.valid && dn.ready;
            assign count   = count_q;

            // Occupancy follows the boundary transfers only; beats moving
            // between internal slices do not change it.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    count_q <= '0;
                end else if (up_fire && !dn_fire) begin
                    count_q <= count_q + CW'(1);
                end else if (!up_fire && dn_fire) begin
                    count_q <= count_q - CW'(1);
                end
            end
        end
    endgenerate

endmodule
